// File: rtl/mcs4_timing_pkg.sv
// Shared timing types for the MCS-4 clock generator: phase states, subcycle
// codes and counter widths.
package mcs4_timing_pkg;

  typedef enum logic [1:0] {
    PH1 = 2'd0,
    G12 = 2'd1,
    PH2 = 2'd2,
    G21 = 2'd3
  } phase_e;

  localparam logic [2:0] A1 = 3'd0;
  localparam logic [2:0] A2 = 3'd1;
  localparam logic [2:0] A3 = 3'd2;
  localparam logic [2:0] M1 = 3'd3;
  localparam logic [2:0] M2 = 3'd4;
  localparam logic [2:0] X1 = 3'd5;
  localparam logic [2:0] X2 = 3'd6;
  localparam logic [2:0] X3 = 3'd7;

  localparam int PHASE_CNT_W = 4;
  localparam int POC_CNT_W   = 8;

  // A phase lasting w cycles is entered with w-1 in its down-counter.
  function automatic logic [PHASE_CNT_W-1:0] phase_load(input int unsigned w);
    phase_load = PHASE_CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/mcs4_poc_timer.sv
// Power-on-clear timer: saturating down-counter of completed clk2 pulses;
// poc_o stays high until the count reaches zero.
module mcs4_poc_timer
  import mcs4_timing_pkg::*;
#(
  parameter int unsigned POC_CLOCKS = 64
) (
  input  logic sysclk_i,
  input  logic poc_ni,
  input  logic dec_i,
  output logic poc_o
);

  logic [POC_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - POC_CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (!poc_ni) begin
      cnt_q <= POC_CNT_W'(POC_CLOCKS);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign poc_o = (cnt_q != '0);

endmodule

// File: rtl/mcs4_clkgen.sv
// MCS-4 two-phase clock, power-on-clear and subcycle tracker for the i4004.
// Define MCS4_CLKGEN_STEP_EN to enable halt / single-step on instruction boundaries.
module mcs4_clkgen
  import mcs4_timing_pkg::*;
#(
  parameter int unsigned PH1_W      = 4,
  parameter int unsigned GAP12_W    = 2,
  parameter int unsigned PH2_W      = 4,
  parameter int unsigned GAP21_W    = 4,
  parameter int unsigned POC_CLOCKS = 64
) (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       sync_pad,
  input  logic       run,
  input  logic       step,
  output logic       clk1_pad,
  output logic       clk2_pad,
  output logic       poc_pad,
  output logic [2:0] subcycle,
  output logic       instr_start,
  output logic       halted,
  output phase_e     dbg_phase_o
);

  // Handshake: none. run is a level, step a one-sysclk pulse; both are
  // sampled only at the end of G21 (or every cycle while halted).

  phase_e                 state_q, state_d;
  logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]             sub_q, sub_d;
  logic                   clk1_q, clk2_q;
  logic                   ist_q, ist_d;
  logic                   halted_q, halted_d;
  logic                   phase_done;
  logic                   poc_dec;
  logic                   hold_g21;

  assign phase_done = (cnt_q == '0);
  assign poc_dec    = (state_q == PH2) && phase_done;

  mcs4_poc_timer #(
    .POC_CLOCKS(POC_CLOCKS)
  ) u_poc_timer (
    .sysclk_i(sysclk),
    .poc_ni  (poc_n),
    .dec_i   (poc_dec),
    .poc_o   (poc_pad)
  );

`ifdef MCS4_CLKGEN_STEP_EN
  // Stay parked in G21 at the end of X3 unless running, in power-on clear,
  // or a step pulse arrives while already parked.
  assign hold_g21 = !run && (sub_q == X3) && !poc_pad && !(halted_q && step);
`else
  logic unused_run_step;
  assign unused_run_step = run ^ step;
  assign hold_g21        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q - PHASE_CNT_W'(1);
    sub_d    = sub_q;
    ist_d    = 1'b0;
    halted_d = 1'b0;
    case (state_q)
      PH1: begin
        if (phase_done) begin
          state_d = G12;
          cnt_d   = phase_load(GAP12_W);
        end
      end
      G12: begin
        if (phase_done) begin
          state_d = PH2;
          cnt_d   = phase_load(PH2_W);
        end
      end
      PH2: begin
        if (phase_done) begin
          state_d = G21;
          cnt_d   = phase_load(GAP21_W);
          // SYNC marks X3; it is meaningless until the CPU leaves clear.
          if (!poc_pad) begin
            sub_d = sync_pad ? X3 : (sub_q + 3'd1);
          end
        end
      end
      G21: begin
        if (phase_done) begin
          if (hold_g21) begin
            cnt_d    = '0;
            halted_d = 1'b1;
          end else begin
            state_d = PH1;
            cnt_d   = phase_load(PH1_W);
            ist_d   = (sub_q == A1);
          end
        end
      end
      default: begin
        state_d = G21;
        cnt_d   = phase_load(GAP21_W);
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      state_q  <= G21;
      cnt_q    <= phase_load(GAP21_W);
      sub_q    <= X3;
      clk1_q   <= 1'b0;
      clk2_q   <= 1'b0;
      ist_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      clk1_q   <= (state_d == PH1);
      clk2_q   <= (state_d == PH2);
      ist_q    <= ist_d;
      halted_q <= halted_d;
    end
  end

  assign clk1_pad    = clk1_q;
  assign clk2_pad    = clk2_q;
  assign subcycle    = sub_q;
  assign instr_start = ist_q;
  assign halted      = halted_q;
  assign dbg_phase_o = state_q;

endmodule
